// File: rtl/fft_pkg.sv
// Shared FFT pipeline types and constants used by the stage-2 index scheduler.
package fft_pkg;

    localparam int N       = 16;
    localparam int IDX_W   = 5;
    localparam int BLK_CNT = 32;
    localparam int DEPTH   = 32;

    typedef logic [N-1:0][IDX_W-1:0] idx_vec_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } m2_sched_state_e;

    localparam logic [1:0] ERR_UDF = 2'b01;
    localparam logic [1:0] ERR_OVF = 2'b10;

endpackage

// File: rtl/fft_idx_fifo.sv
// Synchronous index FIFO; the head entry is presented combinationally on rd_data.
// A write while full is only legal together with a read (caller guarantees this).
module fft_idx_fifo #(
    parameter int W     = 80,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;

    // Extra pointer bit distinguishes full from empty.
    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en && !flush)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/fft_m2_sched.sv
// Stage-2 CBFP index scheduler: pairs stage-0/1 exponent vectors per beat, tracks frame position.
// Optional FFT_M2_SCHED_STATS_EN adds frame_cnt / err_cnt statistics outputs.
module fft_m2_sched
    import fft_pkg::*;
#(
    parameter int N       = fft_pkg::N,
    parameter int IDX_W   = fft_pkg::IDX_W,
    parameter int BLK_CNT = fft_pkg::BLK_CNT,
    parameter int DEPTH   = fft_pkg::DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [N-1:0][IDX_W-1:0]     index_in0,
    input  logic                        valid_in_m0,
    input  logic [N-1:0][IDX_W-1:0]     index_in1,
    input  logic                        valid_in_m1,
    input  logic                        cbfp_req,
    output logic [N-1:0][IDX_W-1:0]     index0_out,
    output logic [N-1:0][IDX_W-1:0]     index1_out,
    output logic                        index_valid,
    output logic                        frame_start,
    output logic                        frame_last,
    output logic                        busy,
    output logic                        err,
    output logic [1:0]                  err_code
`ifdef FFT_M2_SCHED_STATS_EN
    ,
    output logic [15:0]                 frame_cnt,
    output logic [7:0]                  err_cnt
`endif
);
    localparam int W  = N*IDX_W;
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(BLK_CNT);

    m2_sched_state_e      state;
    logic [BW-1:0]        beat_cnt;

    logic [1:0]           vin, wr, full, empty, ovf;
    logic [1:0][W-1:0]    wdat, head;
    logic [1:0][AW:0]     cnt;
    logic                 pop, udf, last_beat, drain;
    logic [1:0]           err_new;

    assign vin  = {valid_in_m1, valid_in_m0};
    assign wdat = {index_in1, index_in0};

    // No write bypass: emptiness is judged on the registered FIFO state only.
    assign pop       = cbfp_req && !(|empty) && (state != ST_ERR);
    assign udf       = cbfp_req && (|empty);
    assign last_beat = (beat_cnt == BW'(BLK_CNT-1));
    assign err_new   = {|ovf, udf};

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        // A full FIFO still accepts a write when the same cycle pops it.
        assign ovf[g] = vin[g] && full[g] && !pop;
        assign wr[g]  = vin[g] && !ovf[g];

        fft_idx_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .wr_en   (wr[g]),
            .wr_data (wdat[g]),
            .rd_en   (pop),
            .rd_data (head[g]),
            .full    (full[g]),
            .empty   (empty[g]),
            .count   (cnt[g])
        );
    end

    // Frame ends and nothing is left queued behind it in either FIFO.
    assign drain = pop && last_beat &&
                   (cnt[0] == (AW+1)'(1)) && !wr[0] &&
                   (cnt[1] == (AW+1)'(1)) && !wr[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            beat_cnt    <= '0;
            index0_out  <= '0;
            index1_out  <= '0;
            index_valid <= 1'b0;
            frame_start <= 1'b0;
            frame_last  <= 1'b0;
            err         <= 1'b0;
            err_code    <= '0;
        end else if (flush) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            beat_cnt    <= '0;
            index0_out  <= '0;
            index1_out  <= '0;
            index_valid <= 1'b0;
            frame_start <= 1'b0;
            frame_last  <= 1'b0;
            err         <= 1'b0;
            err_code    <= '0;
        end else begin
            index_valid <= pop;
            frame_start <= pop && (beat_cnt == '0);
            frame_last  <= pop && last_beat;
            if (pop) begin
                index0_out <= head[0];
                index1_out <= head[1];
                beat_cnt   <= last_beat ? '0 : beat_cnt + 1'b1;
            end
            if (|err_new) begin
                err      <= 1'b1;
                err_code <= err_code | err_new;
            end

            unique case (state)
                ST_IDLE, ST_RUN: begin
                    if (|err_new) begin
                        state <= ST_ERR;
                        busy  <= 1'b0;
                    end else if (pop) begin
                        state <= drain ? ST_IDLE : ST_RUN;
                        busy  <= !drain;
                    end
                end
                ST_ERR: begin
                    state <= ST_ERR;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FFT_M2_SCHED_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else if (flush) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (pop && last_beat)
                frame_cnt <= frame_cnt + 1'b1;
            if ((|err_new) && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: doc/fft_m2_sched.md
# fft_m2_sched

Stage-2 scheduler for the FFT pipeline. It buffers the per-beat CBFP exponent vectors produced by stage 0 and stage 1 and releases them as aligned pairs when the matching stage-2 butterfly data reaches the CBFP unit. It also tracks beat position inside each frame and latches sequencing errors. It sits beside the stage-2 datapath (BF20 → BF21 → BF22 → CBFP2) and drives that CBFP unit's index ports.

## Interface
- `N`, 16: samples per beat (index vector length)
- `IDX_W`, 5: exponent index width
- `BLK_CNT`, 32: beats per frame
- `DEPTH`, 32: index FIFO depth in beats; power of two, ≥ BLK_CNT
- `clk` input 1: single clock, rising edge
- `rst` input 1: asynchronous, active-high reset
- `flush` input 1: synchronous clear of all state
- `index_in0` input N×IDX_W: stage-0 index vector
- `valid_in_m0` input 1: write strobe for `index_in0`
- `index_in1` input N×IDX_W: stage-1 index vector
- `valid_in_m1` input 1: write strobe for `index_in1`
- `cbfp_req` input 1: stage-2 BF22 output beat valid; requests one index pair
- `index0_out` output N×IDX_W: aligned stage-0 vector
- `index1_out` output N×IDX_W: aligned stage-1 vector
- `index_valid` output 1: index pair valid
- `frame_start` output 1: released pair is beat 0 of its frame
- `frame_last` output 1: released pair is beat BLK_CNT-1 of its frame
- `busy` output 1: state is RUN
- `err` output 1: sticky error flag
- `err_code` output 2: 01 = underflow, 10 = overflow, 11 = both

## Operation
- Two independent FIFOs, each DEPTH × (N·IDX_W):
  - FIFO0 is written on `valid_in_m0`; FIFO1 on `valid_in_m1`.
- Write to a full FIFO with no same-cycle read of that FIFO:
  - the write is dropped; `err_code[1]` is set.
- Write to a full FIFO in the same cycle as a read:
  - the write is accepted.
- `cbfp_req` with both FIFOs non-empty:
  - pops both heads into the output registers;
  - increments `beat_cnt`, wrapping from BLK_CNT-1 to 0.
- `cbfp_req` while either FIFO is empty:
  - there is no write bypass, so a same-cycle write does not count;
  - nothing is popped; `err_code[0]` is set;
  - `index_valid` stays 0.
- FSM states: IDLE, RUN, ERR.
  - IDLE→RUN: first successful pop.
  - RUN→IDLE: pop at `beat_cnt`==BLK_CNT-1 while both FIFOs become empty.
  - RUN stays RUN at the frame boundary if more data is queued.
  - any→ERR: any error bit is set.
  - ERR→IDLE: only via `flush` or `rst`.
- In ERR:
  - writes are still accepted (FIFOs keep filling);
  - pops are suppressed;
  - `index_valid` is held at 0.
- `flush`:
  - empties both FIFOs;
  - clears `beat_cnt`, `err`, `err_code`;
  - moves the FSM to IDLE;
  - wins over same-cycle writes and requests.

## Timing
- Latency: `cbfp_req` at cycle t → `index_valid`, `index0_out`, `index1_out`, `frame_start`, `frame_last` at cycle t+1. This is a single-cycle registered pulse.
- The CBFP data path inserts one register stage so data and indices coincide.
- `frame_start`/`frame_last` reflect `beat_cnt` before the increment.
- `err`/`err_code` update at t+1 after the offending event.
- `busy` is the registered state decode.
- Reset values of all outputs are 0; FIFO pointers are 0; state is IDLE.
- `rst` mid-frame: all state is discarded immediately; no partial frame resumes.
- Back-to-back `cbfp_req` every cycle is supported at full throughput.

## Configuration
- `FFT_M2_SCHED_STATS_EN` defined adds two outputs:
  - `frame_cnt` [15:0]: increments on each `frame_last` pulse, wraps at 0xFFFF.
  - `err_cnt` [7:0]: increments per error event, saturates at 0xFF.
  - Both are cleared by `rst` and `flush`.
- Undefined: those ports and their counters are absent; all other behaviour is identical.

## Structure
- Shared package `fft_pkg` holds:
  - N, IDX_W, BLK_CNT constants;
  - `idx_vec_t` (N×IDX_W packed vector);
  - the `m2_sched_state_e` enum;
  - error-code localparams.
- Sub-module `fft_idx_fifo`: synchronous FIFO with full/empty flags, instantiated twice.
- Top level: FSM, beat counter, output registers, error logic.

## Test plan
- Nominal pairing:
  - Stimulus: 32 writes to each FIFO with index value = beat number, then 32 back-to-back `cbfp_req`.
  - Response: 32 `index_valid` pulses, outputs 0..31 in order, `frame_start` on beat 0, `frame_last` on beat 31, `busy` falls after the last pulse.
- Skewed arrival:
  - Stimulus: FIFO0 filled 10 cycles before FIFO1; `cbfp_req` issued only after both are non-empty.
  - Response: no errors; pairs are aligned by beat number.
- Underflow:
  - Stimulus: `cbfp_req` with FIFO1 empty.
  - Response: next cycle `err`=1, `err_code`=01, `index_valid`=0; further requests produce no pops until `flush`.
- Overflow:
  - Stimulus: 33 writes to FIFO0 with no reads.
  - Response: the 33rd write is dropped, `err_code`=10; after `flush`, FIFO0 is empty and `err`=0.
- Boundary:
  - Stimulus: with FIFO0 full, simultaneous write and `cbfp_req`.
  - Response: no overflow; the new entry is popped 32 requests later.
- Reset mid-frame:
  - Stimulus: `rst` asserted after 7 pops, then 32 fresh pairs written and requested.
  - Response: `frame_start` on the first new pop; with `FFT_M2_SCHED_STATS_EN`, `frame_cnt`=1 after completion.
